instruction_encode_writer: RTL and testbench
============================================

// Module: instruction_encode_writer
// PURPOSE
//  Inverse of the instruction decoder: packs decoded RV32I fields (one-hot opcode selection, regs,
//  funct3/7, 32-bit immediate) into 32-bit instruction words and streams them into instruction
//  memory at sequential word addresses. Used by boot/self-test loaders and benches to build programs.
//  Valid/ready input, single output register, write port with ready backpressure.
// PARAMETERS
//  ADDR_WIDTH  10  word-address width of the instruction memory; capacity 2**ADDR_WIDTH words
//  BASE_ADDR   0   first word address written after reset
// PORTS
//  clk                 in   1   clock; all state updates on rising edge
//  reset               in   1   synchronous, active-high reset
//  in_valid            in   1   field bundle valid
//  in_ready            out  1   bundle accepted when in_valid && in_ready
//  opcode_selection    in   11  one-hot, same ONEHOT_*_INDEX bit map as the decoder
//  source_reg_1/2      in   5   rs1 / rs2
//  destination_reg     in   5   rd
//  subfunction_3       in   3   funct3
//  subfunction_7       in   7   funct7 (R-type; imm[11:5] for I-type shifts)
//  immediate           in   32  sign-extended immediate as the decoder would produce it
//  mem_write_enable    out  1   write request; held with address/data until mem_write_ready
//  mem_write_address   out  ADDR_WIDTH  word address
//  mem_write_data      out  32  encoded instruction
//  mem_write_ready     in   1   memory accepts write this cycle
//  encoding_error      out  1   sticky: a bundle was rejected
//  error_address       out  ADDR_WIDTH  address slot of the FIRST rejected bundle
//  memory_full         out  1   all 2**ADDR_WIDTH slots allocated
//  words_written       out  ADDR_WIDTH+1  completed memory writes
// BEHAVIOUR
//  - Reset: mem_write_enable=0, mem_write_address=BASE_ADDR, mem_write_data=0, encoding_error=0,
//    error_address=0, memory_full=0, words_written=0, alloc pointer=BASE_ADDR. Reset mid-transfer
//    drops the pending write; no partial state survives.
//  - in_ready = !memory_full && (!mem_write_enable || mem_write_ready) (skid-free, 1-entry).
//  - Latency: accepted good bundle appears on mem_write_* the next cycle; a write completes on
//    mem_write_enable && mem_write_ready; accept and completion may occur in the same cycle.
//  - Format by opcode_selection: LUI/AUIPC U; JAL J; JALR/LOAD/ITYPE_ALU/FENCE/DEBUG I; BRANCH B;
//    STORE S; RTYPE_ALU R (immediate ignored). Opcode field from the matching *_OPCODE define.
//  - I-type ALU with funct3 001/101: imm[11:5]=subfunction_7, imm[4:0]=immediate[4:0].
//  - Immediate placement is the exact inverse of the decoder bit scatter for every format.
//  - Reject (always): opcode_selection zero or multi-hot. Further checks under the macro below.
//  - Rejected bundle: accepted (handshake completes), not written, alloc pointer still advances
//    (slot left unwritten); encoding_error set; error_address captured only if encoding_error was 0.
//  - Alloc pointer advances by 1 per accepted bundle; memory_full sets when it has advanced
//    2**ADDR_WIDTH times (wraps past top to 0 when BASE_ADDR!=0); cleared only by reset.
//  - words_written increments on each completed write; saturates at 2**ADDR_WIDTH.
// CONFIGURATION
//  ENCODE_STRICT_IMM_EN defined: also reject when immediate does not fit its format: I/S need
//    imm[31:11] all equal; B needs imm[31:12] equal and imm[0]=0; J needs imm[31:20] equal and
//    imm[0]=0; U needs imm[11:0]=0; I-type shifts need immediate[31:5]=0.
//  Not defined: no range checks; out-of-range immediates are silently truncated and written.
// TESTING
//  - ADDI x1,x0,5 (ITYPE_ALU,rd=1,f3=0,imm=5) -> one write, data 0x00500093 at BASE_ADDR, latency 1.
//  - LUI x2,imm=0x12345000 then JAL x1,imm=8 -> 0x12345137 at addr 0, 0x008000EF at addr 1.
//  - BEQ rs1=1,rs2=2,imm=0xFFFFFFFC -> 0xFE208EE3; SRAI x3,x3,4 (f7=0x20) -> 0x4041D193.
//  - mem_write_ready low 3 cycles after a write -> address/data stable, in_ready=0, then completes.
//  - STRICT: ADDI imm=0x800 at slot 2 -> no write, encoding_error=1, error_address=2; next good
//    word lands at 3; second bad bundle leaves error_address=2. Zero opcode_selection rejected too.
//  - ADDR_WIDTH=2: 5 bundles offered -> 4 written, memory_full=1, in_ready=0, words_written=4.

Source files
------------

// File: rtl/instruction_encode_writer.sv
// instruction_encode_writer
//   Packs decoded RV32I field bundles back into 32-bit instruction words and
//   streams them into instruction memory at sequential word addresses.
//   One-entry output register with ready backpressure on the write port.
//   Optional build macro: ENCODE_STRICT_IMM_EN (adds immediate range checks;
//   when undefined, out-of-range immediates are truncated and written).
module instruction_encode_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [10:0]           opcode_selection,
  input  logic [4:0]            source_reg_1,
  input  logic [4:0]            source_reg_2,
  input  logic [4:0]            destination_reg,
  input  logic [2:0]            subfunction_3,
  input  logic [6:0]            subfunction_7,
  input  logic [31:0]           immediate,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [31:0]           mem_write_data,
  input  logic                  mem_write_ready,
  output logic                  encoding_error,
  output logic [ADDR_WIDTH-1:0] error_address,
  output logic                  memory_full,
  output logic [ADDR_WIDTH:0]   words_written
);

  // One-hot bit map shared with the decoder
  localparam int ONEHOT_LUI_INDEX       = 0;
  localparam int ONEHOT_AUIPC_INDEX     = 1;
  localparam int ONEHOT_JAL_INDEX       = 2;
  localparam int ONEHOT_JALR_INDEX      = 3;
  localparam int ONEHOT_BRANCH_INDEX    = 4;
  localparam int ONEHOT_LOAD_INDEX      = 5;
  localparam int ONEHOT_STORE_INDEX     = 6;
  localparam int ONEHOT_ITYPE_ALU_INDEX = 7;
  localparam int ONEHOT_RTYPE_ALU_INDEX = 8;
  localparam int ONEHOT_FENCE_INDEX     = 9;
  localparam int ONEHOT_DEBUG_INDEX     = 10;

  // Major opcode for each one-hot position, indexed by the map above
  localparam logic [6:0] OPCODE_TABLE [0:10] = '{
    7'b0110111,  // LUI
    7'b0010111,  // AUIPC
    7'b1101111,  // JAL
    7'b1100111,  // JALR
    7'b1100011,  // BRANCH
    7'b0000011,  // LOAD
    7'b0100011,  // STORE
    7'b0010011,  // ITYPE_ALU
    7'b0110011,  // RTYPE_ALU
    7'b0001111,  // FENCE
    7'b1110011   // DEBUG (SYSTEM)
  };

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  write_enable_reg;
  logic [ADDR_WIDTH-1:0] write_address_reg;
  logic [31:0]           write_data_reg;
  logic                  encoding_error_reg;
  logic [ADDR_WIDTH-1:0] error_address_reg;
  logic                  memory_full_reg;
  logic [ADDR_WIDTH:0]   words_written_reg;
  logic [ADDR_WIDTH-1:0] alloc_ptr_reg;
  logic [ADDR_WIDTH-1:0] alloc_count_reg;

  logic [6:0]  opcode_terms [0:10];
  logic [6:0]  opcode_field;
  logic        is_u, is_j, is_i, is_b, is_s, is_r, is_shift;
  logic [11:0] i_imm12;
  logic [31:0] encoded_word;
  logic        onehot_ok;
  logic        imm_fits;
  logic        bundle_ok;
  logic        accept;
  logic        complete;

  // Each selection bit gates its own opcode; at most one term is nonzero for a legal bundle
  genvar gi;
  generate
    for (gi = 0; gi < 11; gi++) begin : g_opcode_term
      assign opcode_terms[gi] = opcode_selection[gi] ? OPCODE_TABLE[gi] : 7'd0;
    end
  endgenerate

  assign in_ready = !memory_full_reg && (!write_enable_reg || mem_write_ready);
  assign accept   = in_valid && in_ready;
  assign complete = write_enable_reg && mem_write_ready;

  // Classify the format and scatter the fields into an instruction word
  always_comb begin
    opcode_field = 7'd0;
    for (int i = 0; i < 11; i++) begin
      opcode_field = opcode_field | opcode_terms[i];
    end
    is_u = opcode_selection[ONEHOT_LUI_INDEX] | opcode_selection[ONEHOT_AUIPC_INDEX];
    is_j = opcode_selection[ONEHOT_JAL_INDEX];
    is_i = opcode_selection[ONEHOT_JALR_INDEX] | opcode_selection[ONEHOT_LOAD_INDEX]
         | opcode_selection[ONEHOT_ITYPE_ALU_INDEX] | opcode_selection[ONEHOT_FENCE_INDEX]
         | opcode_selection[ONEHOT_DEBUG_INDEX];
    is_b = opcode_selection[ONEHOT_BRANCH_INDEX];
    is_s = opcode_selection[ONEHOT_STORE_INDEX];
    is_r = opcode_selection[ONEHOT_RTYPE_ALU_INDEX];
    // Shifts carry funct7 in imm[11:5] and the shift amount in imm[4:0]
    is_shift = opcode_selection[ONEHOT_ITYPE_ALU_INDEX]
             && (subfunction_3 == 3'b001 || subfunction_3 == 3'b101);
    i_imm12 = is_shift ? {subfunction_7, immediate[4:0]} : immediate[11:0];

    encoded_word = 32'd0;
    if (is_u) begin
      encoded_word = {immediate[31:12], destination_reg, opcode_field};
    end else if (is_j) begin
      encoded_word = {immediate[20], immediate[10:1], immediate[11], immediate[19:12],
                      destination_reg, opcode_field};
    end else if (is_i) begin
      encoded_word = {i_imm12, source_reg_1, subfunction_3, destination_reg, opcode_field};
    end else if (is_b) begin
      encoded_word = {immediate[12], immediate[10:5], source_reg_2, source_reg_1, subfunction_3,
                      immediate[4:1], immediate[11], opcode_field};
    end else if (is_s) begin
      encoded_word = {immediate[11:5], source_reg_2, source_reg_1, subfunction_3,
                      immediate[4:0], opcode_field};
    end else if (is_r) begin
      encoded_word = {subfunction_7, source_reg_2, source_reg_1, subfunction_3,
                      destination_reg, opcode_field};
    end

    onehot_ok = (opcode_selection != 11'd0)
             && ((opcode_selection & (opcode_selection - 11'd1)) == 11'd0);

`ifdef ENCODE_STRICT_IMM_EN
    // Sign-extension bits must all agree and alignment bits must be clear
    imm_fits = 1'b1;
    if (is_u) begin
      imm_fits = (immediate[11:0] == 12'd0);
    end else if (is_j) begin
      imm_fits = ((&immediate[31:20]) || !(|immediate[31:20])) && !immediate[0];
    end else if (is_b) begin
      imm_fits = ((&immediate[31:12]) || !(|immediate[31:12])) && !immediate[0];
    end else if (is_i && is_shift) begin
      imm_fits = (immediate[31:5] == 27'd0);
    end else if (is_i || is_s) begin
      imm_fits = (&immediate[31:11]) || !(|immediate[31:11]);
    end
`else
    imm_fits = 1'b1;
`endif

    bundle_ok = onehot_ok && imm_fits;
  end

  // Output register, slot allocation, error capture and write accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable_reg   <= 1'b0;
      write_address_reg  <= BASE;
      write_data_reg     <= 32'd0;
      encoding_error_reg <= 1'b0;
      error_address_reg  <= '0;
      memory_full_reg    <= 1'b0;
      words_written_reg  <= '0;
      alloc_ptr_reg      <= BASE;
      alloc_count_reg    <= '0;
    end else begin
      if (complete) begin
        write_enable_reg <= 1'b0;
      end
      if (accept) begin
        alloc_ptr_reg   <= alloc_ptr_reg + 1'b1;
        alloc_count_reg <= alloc_count_reg + 1'b1;
        if (alloc_count_reg == {ADDR_WIDTH{1'b1}}) begin
          memory_full_reg <= 1'b1;
        end
        if (bundle_ok) begin
          write_enable_reg  <= 1'b1;
          write_address_reg <= alloc_ptr_reg;
          write_data_reg    <= encoded_word;
        end else begin
          // A rejected bundle still consumes its slot; only the first one is recorded
          encoding_error_reg <= 1'b1;
          if (!encoding_error_reg) begin
            error_address_reg <= alloc_ptr_reg;
          end
        end
      end
      if (complete && words_written_reg != CAPACITY) begin
        words_written_reg <= words_written_reg + 1'b1;
      end
    end
  end

  assign mem_write_enable  = write_enable_reg;
  assign mem_write_address = write_address_reg;
  assign mem_write_data    = write_data_reg;
  assign encoding_error    = encoding_error_reg;
  assign error_address     = error_address_reg;
  assign memory_full       = memory_full_reg;
  assign words_written     = words_written_reg;

endmodule

// File: tb/tb_instruction_encode_writer.sv
// Directed testbench for instruction_encode_writer: a 1024-word instance for
// encoding/handshake/error checks and a 4-word instance (base 1) for fill-up.
module tb_instruction_encode_writer;

  localparam int LUI = 0, AUIPC = 1, JAL = 2, JALR = 3, BRANCH = 4, LOAD = 5;
  localparam int STORE = 6, ITYPE = 7, RTYPE = 8, FENCE = 9, DEBUG = 10;

`ifdef ENCODE_STRICT_IMM_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef struct {
    logic [10:0] sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] expected;
    string       name;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [10:0] sel;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;

  logic        a_valid, a_in_ready, a_we, a_mready, a_err, a_full;
  logic [9:0]  a_addr, a_err_addr;
  logic [31:0] a_data;
  logic [10:0] a_ww;

  logic        b_valid, b_in_ready, b_we, b_mready, b_err, b_full;
  logic [1:0]  b_addr, b_err_addr;
  logic [31:0] b_data;
  logic [2:0]  b_ww;

  int checks = 0;
  int failures = 0;

  instruction_encode_writer #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_in_ready),
    .opcode_selection(sel), .source_reg_1(rs1), .source_reg_2(rs2), .destination_reg(rd),
    .subfunction_3(f3), .subfunction_7(f7), .immediate(imm),
    .mem_write_enable(a_we), .mem_write_address(a_addr), .mem_write_data(a_data),
    .mem_write_ready(a_mready), .encoding_error(a_err), .error_address(a_err_addr),
    .memory_full(a_full), .words_written(a_ww)
  );

  instruction_encode_writer #(.ADDR_WIDTH(2), .BASE_ADDR(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_in_ready),
    .opcode_selection(sel), .source_reg_1(rs1), .source_reg_2(rs2), .destination_reg(rd),
    .subfunction_3(f3), .subfunction_7(f7), .immediate(imm),
    .mem_write_enable(b_we), .mem_write_address(b_addr), .mem_write_data(b_data),
    .mem_write_ready(b_mready), .encoding_error(b_err), .error_address(b_err_addr),
    .memory_full(b_full), .words_written(b_ww)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_fields(input logic [10:0] s, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] d, input logic [2:0] fn3, input logic [6:0] fn7,
                            input logic [31:0] im);
    sel = s; rs1 = r1; rs2 = r2; rd = d; f3 = fn3; f7 = fn7; imm = im;
  endtask

  // Offer one bundle and return #1 after the edge that accepted it
  task automatic drive(input bit to_b, input logic [10:0] s, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] d, input logic [2:0] fn3,
                       input logic [6:0] fn7, input logic [31:0] im, input string tag);
    int waited = 0;
    set_fields(s, r1, r2, d, fn3, fn7, im);
    if (to_b) b_valid = 1'b1; else a_valid = 1'b1;
    while (!(to_b ? b_in_ready : a_in_ready) && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (waited >= 20) begin
      failures++;
      $display("FAIL %s_accept timed out waiting for in_ready", tag);
    end else begin
      @(posedge clk); #1;
      $display("txn %s dut=%s sel=%h imm=%h -> we=%0b addr=%0d data=%h", tag, to_b ? "b" : "a",
               s, im, to_b ? b_we : a_we, to_b ? b_addr : a_addr, to_b ? b_data : a_data);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", a_we); end
    checks++; if (a_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", a_addr); end
    checks++; if (a_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", a_data); end
    checks++; if (a_err !== 1'b0 || a_err_addr !== 10'd0) begin failures++; $display("FAIL reset_err got=%0b/%0d exp=0/0", a_err, a_err_addr); end
    checks++; if (a_full !== 1'b0 || a_ww !== 11'd0) begin failures++; $display("FAIL reset_full_ww got=%0b/%0d exp=0/0", a_full, a_ww); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); end
    checks++; if (b_addr !== 2'd1) begin failures++; $display("FAIL reset_b_base_addr got=%0d exp=1", b_addr); end
  endtask

  task automatic test_addi();
    do_reset();
    drive(1'b0, 11'(1 << ITYPE), 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd5, "addi");
    checks++; if (a_we !== 1'b1) begin failures++; $display("FAIL addi_we got=%0b exp=1", a_we); end
    checks++; if (a_addr !== 10'd0) begin failures++; $display("FAIL addi_addr got=%0d exp=0", a_addr); end
    checks++; if (a_data !== 32'h00500093) begin failures++; $display("FAIL addi_data got=%h exp=00500093", a_data); end
    @(posedge clk); #1;
    checks++; if (a_we !== 1'b0 || a_ww !== 11'd1) begin failures++; $display("FAIL addi_complete got we=%0b ww=%0d exp we=0 ww=1", a_we, a_ww); end
  endtask

  task automatic test_lui_jal();
    do_reset();
    drive(1'b0, 11'(1 << LUI), 5'd0, 5'd0, 5'd2, 3'd0, 7'd0, 32'h12345000, "lui");
    checks++; if (a_addr !== 10'd0 || a_data !== 32'h12345137) begin failures++; $display("FAIL lui_word got=%0d:%h exp=0:12345137", a_addr, a_data); end
    drive(1'b0, 11'(1 << JAL), 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd8, "jal");
    checks++; if (a_addr !== 10'd1 || a_data !== 32'h008000EF) begin failures++; $display("FAIL jal_word got=%0d:%h exp=1:008000ef", a_addr, a_data); end
    @(posedge clk); #1;
    checks++; if (a_ww !== 11'd2) begin failures++; $display("FAIL lui_jal_count got=%0d exp=2", a_ww); end
  endtask

  task automatic test_formats();
    vec_t v [10];
    v[0] = '{11'(1 << BRANCH), 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,    32'hFFFFFFFC, 32'hFE208EE3, "beq"};
    v[1] = '{11'(1 << ITYPE),  5'd3, 5'd0, 5'd3, 3'd5, 7'h20,   32'd4,        32'h4041D193, "srai"};
    v[2] = '{11'(1 << STORE),  5'd2, 5'd5, 5'd0, 3'd2, 7'd0,    32'd12,       32'h00512623, "sw"};
    v[3] = '{11'(1 << RTYPE),  5'd1, 5'd2, 5'd3, 3'd0, 7'd0,    32'hFFFFFFFF, 32'h002081B3, "add"};
    v[4] = '{11'(1 << RTYPE),  5'd1, 5'd2, 5'd3, 3'd0, 7'h20,   32'd0,        32'h402081B3, "sub"};
    v[5] = '{11'(1 << AUIPC),  5'd0, 5'd0, 5'd5, 3'd0, 7'd0,    32'h00001000, 32'h00001297, "auipc"};
    v[6] = '{11'(1 << LOAD),   5'd1, 5'd0, 5'd6, 3'd2, 7'd0,    32'hFFFFFFFC, 32'hFFC0A303, "lw"};
    v[7] = '{11'(1 << JALR),   5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd0,        32'h00008067, "jalr"};
    v[8] = '{11'(1 << FENCE),  5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'h000000FF, 32'h0FF0000F, "fence"};
    v[9] = '{11'(1 << DEBUG),  5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd1,        32'h00100073, "ebreak"};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, v[i].sel, v[i].rs1, v[i].rs2, v[i].rd, v[i].f3, v[i].f7, v[i].imm, v[i].name);
      checks++; if (a_data !== v[i].expected || a_addr !== 10'(i)) begin failures++; $display("FAIL %s_word got=%0d:%h exp=%0d:%h", v[i].name, a_addr, a_data, i, v[i].expected); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, 11'(1 << ITYPE), 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd5, "bp_addi");
    a_mready = 1'b0;
    set_fields(11'(1 << LUI), 5'd0, 5'd0, 5'd2, 3'd0, 7'd0, 32'h12345000);
    a_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (a_we !== 1'b1 || a_addr !== 10'd0 || a_data !== 32'h00500093) begin failures++; $display("FAIL stall_hold cycle=%0d got=%0b:%0d:%h exp=1:0:00500093", c, a_we, a_addr, a_data); end
      checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cycle=%0d got=%0b exp=0", c, a_in_ready); end
    end
    a_mready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", a_in_ready); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    $display("txn bp_lui dut=a accepted with completion -> addr=%0d data=%h", a_addr, a_data);
    checks++; if (a_addr !== 10'd1 || a_data !== 32'h12345137 || a_ww !== 11'd1) begin failures++; $display("FAIL overlap got=%0d:%h ww=%0d exp=1:12345137 ww=1", a_addr, a_data, a_ww); end
    @(posedge clk); #1;
    checks++; if (a_we !== 1'b0 || a_ww !== 11'd2) begin failures++; $display("FAIL overlap_done got we=%0b ww=%0d exp we=0 ww=2", a_we, a_ww); end
    // Reset while a write is stalled drops it
    a_mready = 1'b0;
    drive(1'b0, 11'(1 << ITYPE), 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd5, "drop_addi");
    do_reset();
    a_mready = 1'b1;
    checks++; if (a_we !== 1'b0 || a_addr !== 10'd0 || a_ww !== 11'd0) begin failures++; $display("FAIL reset_drop got we=%0b addr=%0d ww=%0d exp 0/0/0", a_we, a_addr, a_ww); end
  endtask

  task automatic test_reject();
    logic [9:0] exp_err_addr;
    do_reset();
    drive(1'b0, 11'(1 << ITYPE), 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd5, "rej_good0");
    drive(1'b0, 11'(1 << ITYPE), 5'd0, 5'd0, 5'd2, 3'd0, 7'd0, 32'd6, "rej_good1");
    drive(1'b0, 11'(1 << ITYPE), 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'h800, "imm_800");
    if (STRICT) begin
      checks++; if (a_we !== 1'b0 || a_err !== 1'b1 || a_err_addr !== 10'd2) begin failures++; $display("FAIL strict_range got we=%0b err=%0b addr=%0d exp 0/1/2", a_we, a_err, a_err_addr); end
    end else begin
      checks++; if (a_we !== 1'b1 || a_data !== 32'h80000093 || a_err !== 1'b0) begin failures++; $display("FAIL truncate got we=%0b data=%h err=%0b exp 1/80000093/0", a_we, a_data, a_err); end
    end
    exp_err_addr = STRICT ? 10'd2 : 10'd3;
    drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd5, "zero_sel");
    checks++; if (a_we !== 1'b0 || a_err !== 1'b1 || a_err_addr !== exp_err_addr) begin failures++; $display("FAIL zero_sel got we=%0b err=%0b addr=%0d exp 0/1/%0d", a_we, a_err, a_err_addr, exp_err_addr); end
    drive(1'b0, 11'(1 << ITYPE), 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd5, "after_err");
    checks++; if (a_we !== 1'b1 || a_addr !== 10'd4 || a_data !== 32'h00500093) begin failures++; $display("FAIL after_err got %0b:%0d:%h exp 1:4:00500093", a_we, a_addr, a_data); end
    drive(1'b0, 11'((1 << LUI) | (1 << JAL)), 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd0, "multi_hot");
    checks++; if (a_we !== 1'b0 || a_err !== 1'b1 || a_err_addr !== exp_err_addr) begin failures++; $display("FAIL multi_hot got we=%0b err=%0b addr=%0d exp 0/1/%0d", a_we, a_err, a_err_addr, exp_err_addr); end
    @(posedge clk); #1;
    checks++; if (a_ww !== (STRICT ? 11'd3 : 11'd4)) begin failures++; $display("FAIL reject_count got=%0d exp=%0d", a_ww, STRICT ? 3 : 4); end
  endtask

  task automatic test_memory_full();
    logic [1:0] exp_addr [4];
    exp_addr[0] = 2'd1; exp_addr[1] = 2'd2; exp_addr[2] = 2'd3; exp_addr[3] = 2'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 11'(1 << ITYPE), 5'd0, 5'd0, 5'(i + 1), 3'd0, 7'd0, 32'd5, "fill");
      checks++; if (b_addr !== exp_addr[i] || b_data !== (32'h00500013 | (32'(i + 1) << 7))) begin failures++; $display("FAIL fill_word%0d got=%0d:%h exp=%0d:%h", i, b_addr, b_data, exp_addr[i], 32'h00500013 | (32'(i + 1) << 7)); end
      checks++; if (b_full !== (i == 3)) begin failures++; $display("FAIL fill_full%0d got=%0b exp=%0b", i, b_full, i == 3); end
    end
    set_fields(11'(1 << ITYPE), 5'd0, 5'd0, 5'd9, 3'd0, 7'd0, 32'd5);
    b_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready cycle=%0d got=%0b exp=0", c, b_in_ready); end
    end
    b_valid = 1'b0;
    checks++; if (b_ww !== 3'd4 || b_full !== 1'b1 || b_we !== 1'b0 || b_addr !== 2'd0) begin failures++; $display("FAIL full_final got ww=%0d full=%0b we=%0b addr=%0d exp 4/1/0/0", b_ww, b_full, b_we, b_addr); end
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_mready = 1'b1; b_mready = 1'b1;
    set_fields(11'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    test_reset();
    test_addi();
    test_lui_jal();
    test_formats();
    test_back_to_back();
    test_reject();
    test_memory_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
